// File: rtl/ram_access_arbiter.sv
// Round-robin access controller for a single-port 256x8 command-driven RAM.
// Expands each granted read/write transaction into the RAM's 10-bit command sequence.
module ram_access_arbiter #(
  parameter int TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [1:0] we,
  input  logic [7:0] addr0,
  input  logic [7:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic [1:0] ack,
  output logic [7:0] rdata,
  output logic       err,
  output logic       busy,
  output logic [9:0] ram_din,
  output logic       ram_rx_valid,
  input  logic [7:0] ram_dout,
  input  logic       ram_tx_valid
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_W_ADDR = 3'd1;
  localparam logic [2:0] S_W_DATA = 3'd2;
  localparam logic [2:0] S_R_ADDR = 3'd3;
  localparam logic [2:0] S_R_CMD  = 3'd4;
  localparam logic [2:0] S_R_WAIT = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

  logic [2:0] state;
  logic       gnt;
  logic       prio;
  logic       tout;
  logic [3:0] cnt;
  logic [7:0] rdata_q;
  logic [7:0] t_addr;
  logic [7:0] t_wdata;
  logic       sel;
  logic       grant_now;

  // prio names the requester that wins the next contention; a cleared
  // pointer therefore favours requester 0 after reset.
  always_comb begin
    sel       = (req == 2'b11) ? prio : req[1];
    grant_now = (state == S_IDLE) && (req != 2'b00);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      gnt     <= 1'b0;
      prio    <= 1'b0;
      tout    <= 1'b0;
      cnt     <= 4'd0;
      rdata_q <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_now) begin
            gnt   <= sel;
            prio  <= ~sel;
            tout  <= 1'b0;
            state <= we[sel] ? S_W_ADDR : S_R_ADDR;
          end
        end
        S_W_ADDR: state <= S_W_DATA;
        S_W_DATA: state <= S_DONE;
        S_R_ADDR: state <= S_R_CMD;
        S_R_CMD: begin
          cnt   <= 4'd0;
          state <= S_R_WAIT;
        end
        S_R_WAIT: begin
          if (ram_tx_valid) begin
            rdata_q <= ram_dout;
            state   <= S_DONE;
          end else if (cnt == CNT_LAST) begin
            rdata_q <= 8'h00;
            tout    <= 1'b1;
            state   <= S_DONE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Transaction fields are captured only at grant and held for the whole transaction.
  always_ff @(posedge clk) begin
    if (grant_now) begin
      t_addr  <= sel ? addr1 : addr0;
      t_wdata <= sel ? wdata1 : wdata0;
    end
  end

  always_comb begin
    ack          = 2'b00;
    err          = 1'b0;
    ram_din      = 10'h000;
    ram_rx_valid = 1'b0;
    case (state)
      S_W_ADDR: begin
        ram_din      = {2'b00, t_addr};
        ram_rx_valid = 1'b1;
      end
      S_W_DATA: begin
        ram_din      = {2'b01, t_wdata};
        ram_rx_valid = 1'b1;
      end
      S_R_ADDR: begin
        ram_din      = {2'b10, t_addr};
        ram_rx_valid = 1'b1;
      end
      S_R_CMD: begin
        ram_din      = {2'b11, 8'h00};
        ram_rx_valid = 1'b1;
      end
      S_DONE: begin
        ack = gnt ? 2'b10 : 2'b01;
        err = tout;
      end
      default: ;
    endcase
  end

  assign busy  = (state != S_IDLE);
  assign rdata = rdata_q;

endmodule
